minmax_stream: RTL and testbench
================================

# minmax_stream

Streaming min/max reducer: accepts a frame of `WIDTH`-bit samples over a valid/ready interface and returns the frame's minimum or maximum, its first index, the sample count, and an all-equal flag. It is the parametrised, sequential successor of the two-operand min/max selector. It sits between a sample source and any consumer needing per-frame extrema.

## Interface
Parameters:
- `WIDTH`, 8: sample width in bits.
- `FRAME_LEN`, 16: maximum samples per frame; must be ≥ 2.
- `SIGNED`, 0: 1 selects two's-complement comparison; 0 selects unsigned.
- `IDX_W` (derived) = `$clog2(FRAME_LEN)`.
- `CNT_W` (derived) = `$clog2(FRAME_LEN+1)`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `min_max`, in, 1: mode select; 1 = minimum, 0 = maximum. Sampled only on a frame's first accepted sample.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: block can accept a sample.
- `in_data`, in, `WIDTH`: input sample.
- `in_last`, in, 1: marks the final sample of a short frame.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_value`, out, `WIDTH`: extremum of the frame.
- `out_index`, out, `IDX_W`: zero-based index of the first occurrence of the extremum.
- `out_count`, out, `CNT_W`: number of samples in the frame.
- `out_all_equal`, out, 1: every sample in the frame is equal.

## Operation
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, accepting samples.
  - HOLD: result presented, waiting for the consumer.
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- IDLE → ACCUM on the first transfer:
  - best ← `in_data`; idx ← 0; cnt ← 1; eq ← 1; mode ← `min_max`.
- Each subsequent transfer in ACCUM, with sample index k = cnt:
  - Replace best/idx only when the sample is strictly better: `in_data < best` in min mode, `in_data > best` in max mode. Ties keep the earliest index.
  - eq ← eq && (`in_data` == best_at_frame_start). Equivalent rule: eq clears on any sample differing from sample 0.
  - cnt increments.
- Frame closes on the transfer carrying `in_last`, or on the transfer that makes cnt == `FRAME_LEN`, whichever comes first. The state then goes to HOLD and the outputs load.
- A single-sample frame (`in_last` on the first transfer) goes IDLE → HOLD directly: count 1, index 0, all_equal 1.
- HOLD → IDLE on an output transfer.
- `in_ready` = !`out_valid`, so input is stalled during HOLD.
- Comparison uses `$signed` when `SIGNED`=1. Widths never extend beyond `WIDTH`; there is no arithmetic overflow.
- Reset (asynchronous, at any time, including mid-frame):
  - State → IDLE; all internal accumulators cleared.
  - `out_valid`=0, `out_value`=0, `out_index`=0, `out_count`=0, `out_all_equal`=0.
  - `in_ready`=1.
  - A partial frame is discarded, not reported.

## Timing
- One sample per cycle while in ACCUM; there are no internal bubbles.
- Latency: `out_valid` rises on the clock edge of the closing input transfer, i.e. it is visible in the next cycle.
- Result outputs are registered and stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` falls in the same cycle `out_valid` rises. It returns high the cycle after the output transfer.
- Minimum spacing between frames is therefore one idle input cycle per result handshake.
- `min_max` changes mid-frame have no effect.
- `in_last` on a cycle without `in_valid` is ignored.

## Structure
- Package `minmax_pkg`:
  - enum `mode_e` (MODE_MAX=0, MODE_MIN=1);
  - enum `state_e` (IDLE, ACCUM, HOLD);
  - localparam helpers for `IDX_W`/`CNT_W`.
- Sub-module `minmax_cmp` (params `WIDTH`, `SIGNED`): a combinational comparator producing `lt` and `eq` for operands a, b. It is instantiated once for best-vs-sample and once for sample-vs-first.
- The top level holds the FSM, accumulators and output registers.

## Test plan
- Min mode, unsigned, samples 0x50,0x20,0x90,0x20 with `in_last` on the 4th → value 0x20, index 1, count 4, all_equal 0.
- Max mode with samples 0x7F,0x80:
  - `SIGNED`=1 → value 0x7F, index 0.
  - `SIGNED`=0 → value 0x80, index 1.
- Full frame of 16 samples 0x2A with no `in_last` → `out_valid` after the 16th transfer; value 0x2A, index 0, count 16, all_equal 1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable throughout. After the handshake, the next frame's index restarts at 0.
- `min_max` toggled from 1 to 0 after the first sample of 3,1,7 → min retained: value 1, index 1.
- Assert `rst` after 5 of 16 samples → all outputs 0 and `in_ready`=1 immediately. The following 2-sample frame reports count 2.

Source files
------------

// File: rtl/minmax_pkg.sv
// minmax_pkg: shared types and width helpers for the streaming min/max reducer.
package minmax_pkg;

  // Reduction direction, latched on the first sample of each frame.
  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  // Frame controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Smallest frame the controller is built for.
  localparam int FRAME_LEN_MIN = 2;

  // Bits needed for a zero-based sample index within a frame.
  function automatic int idx_width(input int frame_len);
    return (frame_len < FRAME_LEN_MIN) ? 1 : $clog2(frame_len);
  endfunction

  // Bits needed for a sample count from 0 up to and including frame_len.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/minmax_cmp.sv
// minmax_cmp: combinational magnitude comparator, signed or unsigned by parameter.
module minmax_cmp #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq
);

  // The signedness is fixed at elaboration, so only one compare is built.
  generate
    if (SIGNED != 0) begin : g_signed
      assign lt = ($signed(a) < $signed(b));
    end else begin : g_unsigned
      assign lt = (a < b);
    end
  endgenerate

  assign eq = (a == b);

endmodule

// File: rtl/minmax_stream.sv
// minmax_stream: per-frame min/max reducer with first-index, count and all-equal
// reporting. Samples arrive on a valid/ready stream; one registered result per frame.
module minmax_stream
  import minmax_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  FRAME_LEN = 16,
  parameter int  SIGNED    = 0,
  localparam int IDX_W     = idx_width(FRAME_LEN),
  localparam int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             min_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all_equal
);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

  // Controller state and running accumulators.
  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_q, eq_d;

  // Registered result.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_all_equal_q, out_all_equal_d;

  // Comparator results and transfer qualifiers.
  logic best_lt, best_eq;
  logic first_lt, first_eq;
  logic in_xfer, out_xfer;
  logic better, same_as_first, frame_close;

  assign in_ready = !out_valid_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Incoming sample against the current extremum.
  minmax_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp_best (
    .a  (in_data),
    .b  (best_q),
    .lt (best_lt),
    .eq (best_eq)
  );

  // Incoming sample against sample 0, for the all-equal flag.
  minmax_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp_first (
    .a  (in_data),
    .b  (first_q),
    .lt (first_lt),
    .eq (first_eq)
  );

  // Only a strictly better sample replaces the extremum, so ties keep the earliest index.
  assign better = (mode_q == MODE_MIN) ? best_lt : (!best_lt && !best_eq);

  // A sample matches sample 0 only when it is neither below it nor different from it.
  assign same_as_first = first_eq && !first_lt;

  // Next-state, accumulator update and result load; everything holds by default.
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    best_d          = best_q;
    first_d         = first_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    eq_d            = eq_q;
    out_valid_d     = out_valid_q;
    out_value_d     = out_value_q;
    out_index_d     = out_index_q;
    out_count_d     = out_count_q;
    out_all_equal_d = out_all_equal_q;
    frame_close     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          // First sample opens the frame and fixes the mode for its duration.
          mode_d  = mode_e'(min_max);
          best_d  = in_data;
          first_d = in_data;
          idx_d   = '0;
          cnt_d   = CNT_W'(1);
          eq_d    = 1'b1;
          if (in_last) begin
            state_d     = HOLD;
            frame_close = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (in_xfer) begin
          // The current count is the zero-based index of this sample.
          cnt_d = cnt_q + CNT_W'(1);
          if (better) begin
            best_d = in_data;
            idx_d  = cnt_q[IDX_W-1:0];
          end
          eq_d = eq_q && same_as_first;
          if (in_last || (cnt_d == FRAME_LEN_C)) begin
            state_d     = HOLD;
            frame_close = 1'b1;
          end
        end
      end

      HOLD: begin
        if (out_xfer) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The closing sample is folded in before the result is captured.
    if (frame_close) begin
      out_valid_d     = 1'b1;
      out_value_d     = best_d;
      out_index_d     = idx_d;
      out_count_d     = cnt_d;
      out_all_equal_d = eq_d;
    end
  end

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_MAX;
      best_q  <= '0;
      first_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      best_q  <= best_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
    end
  end

  // Result registers; held steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_value_q     <= '0;
      out_index_q     <= '0;
      out_count_q     <= '0;
      out_all_equal_q <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_value_q     <= out_value_d;
      out_index_q     <= out_index_d;
      out_count_q     <= out_count_d;
      out_all_equal_q <= out_all_equal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_value     = out_value_q;
  assign out_index     = out_index_q;
  assign out_count     = out_count_q;
  assign out_all_equal = out_all_equal_q;

endmodule

// File: tb/tb_minmax_stream.sv
// tb_minmax_stream: drives one stimulus stream into an unsigned and a signed
// instance and scores each frame result against a behavioural reference.
module tb_minmax_stream;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 16;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] count;
    logic             all_eq;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             min_max;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_ready;

  logic             u_in_ready, u_out_valid, u_out_all_equal;
  logic [WIDTH-1:0] u_out_value;
  logic [IDX_W-1:0] u_out_index;
  logic [CNT_W-1:0] u_out_count;

  logic             s_in_ready, s_out_valid, s_out_all_equal;
  logic [WIDTH-1:0] s_out_value;
  logic [IDX_W-1:0] s_out_index;
  logic [CNT_W-1:0] s_out_count;

  exp_t             exp_u[$];
  exp_t             exp_s[$];
  logic [WIDTH-1:0] frame_buf [FRAME_LEN];

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  minmax_stream #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .SIGNED    (0)
  ) dut_u (
    .clk           (clk),
    .rst           (rst),
    .min_max       (min_max),
    .in_valid      (in_valid),
    .in_ready      (u_in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (u_out_valid),
    .out_ready     (out_ready),
    .out_value     (u_out_value),
    .out_index     (u_out_index),
    .out_count     (u_out_count),
    .out_all_equal (u_out_all_equal)
  );

  minmax_stream #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .SIGNED    (1)
  ) dut_s (
    .clk           (clk),
    .rst           (rst),
    .min_max       (min_max),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (s_out_valid),
    .out_ready     (out_ready),
    .out_value     (s_out_value),
    .out_index     (s_out_index),
    .out_count     (s_out_count),
    .out_all_equal (s_out_all_equal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: strict improvement keeps the first occurrence of the extremum.
  function automatic exp_t ref_model(input int n, input bit mode_min, input bit is_signed);
    exp_t r;
    int   best;
    int   v;
    r.value  = frame_buf[0];
    r.index  = '0;
    r.count  = CNT_W'(n);
    r.all_eq = 1'b1;
    best = is_signed ? int'($signed(frame_buf[0])) : int'(frame_buf[0]);
    for (int i = 1; i < n; i++) begin
      v = is_signed ? int'($signed(frame_buf[i])) : int'(frame_buf[i]);
      if (mode_min ? (v < best) : (v > best)) begin
        best    = v;
        r.value = frame_buf[i];
        r.index = IDX_W'(i);
      end
      if (frame_buf[i] != frame_buf[0]) r.all_eq = 1'b0;
    end
    return r;
  endfunction

  task automatic check_result(input string who, input exp_t e, input logic [WIDTH-1:0] v,
                              input logic [IDX_W-1:0] ix, input logic [CNT_W-1:0] c,
                              input logic ae);
    check_eq({who, "_value"}, 32'(v), 32'(e.value));
    check_eq({who, "_index"}, 32'(ix), 32'(e.index));
    check_eq({who, "_count"}, 32'(c), 32'(e.count));
    check_eq({who, "_all_equal"}, 32'(ae), 32'(e.all_eq));
    $display("%s result: value=%02h index=%0d count=%0d all_equal=%0b", who, v, ix, c, ae);
  endtask

  // Output monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_ready && u_out_valid) begin
      if (exp_u.size() == 0) check_eq("u_unexpected_result", 32'd1, 32'd0);
      else check_result("u", exp_u.pop_front(), u_out_value, u_out_index, u_out_count, u_out_all_equal);
    end
    if (!rst && out_ready && s_out_valid) begin
      if (exp_s.size() == 0) check_eq("s_unexpected_result", 32'd1, 32'd0);
      else check_result("s", exp_s.pop_front(), s_out_value, s_out_index, s_out_count, s_out_all_equal);
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!u_in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!u_in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Sends frame_buf[0..n-1]; called and returns at 1 time unit after a rising edge.
  task automatic send_frame(input int n, input bit mode_min, input bit use_last,
                            input bit toggle_mode);
    exp_u.push_back(ref_model(n, mode_min, 1'b0));
    exp_s.push_back(ref_model(n, mode_min, 1'b1));
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = frame_buf[i];
      in_last  = use_last && (i == n - 1);
      min_max  = (toggle_mode && i > 0) ? !mode_min : mode_min;
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_u.size() != 0 || exp_s.size() != 0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_u.size() != 0 || exp_s.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_u.size() + exp_s.size()), 32'd0);
      exp_u.delete();
      exp_s.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_u_out_valid"}, 32'(u_out_valid), 32'd0);
    check_eq({tag, "_u_in_ready"}, 32'(u_in_ready), 32'd1);
    check_eq({tag, "_u_outputs"}, 32'({u_out_value, u_out_index, u_out_count, u_out_all_equal}), 32'd0);
    check_eq({tag, "_s_out_valid"}, 32'(s_out_valid), 32'd0);
    check_eq({tag, "_s_in_ready"}, 32'(s_in_ready), 32'd1);
    check_eq({tag, "_s_outputs"}, 32'({s_out_value, s_out_index, s_out_count, s_out_all_equal}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    bit ul;
    rst = 1'b1; min_max = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Min mode: 50,20,90,20 with last on the fourth.
    frame_buf[0] = 8'h50; frame_buf[1] = 8'h20; frame_buf[2] = 8'h90; frame_buf[3] = 8'h20;
    send_frame(4, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Max mode: 7F,80 distinguishes signed from unsigned ordering.
    frame_buf[0] = 8'h7F; frame_buf[1] = 8'h80;
    send_frame(2, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Full frame of 16 equal samples, closed by length alone.
    for (int i = 0; i < FRAME_LEN; i++) frame_buf[i] = 8'h2A;
    exp_u.push_back(ref_model(FRAME_LEN, 1'b0, 1'b0));
    exp_s.push_back(ref_model(FRAME_LEN, 1'b0, 1'b1));
    min_max = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1'b1; in_data = frame_buf[i]; in_last = 1'b0;
      @(posedge clk); #1;
      if (i == FRAME_LEN - 2) check_eq("full_out_valid_early", 32'(u_out_valid), 32'd0);
      if (i == FRAME_LEN - 1) check_eq("full_out_valid_after_16", 32'(u_out_valid), 32'd1);
    end
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: result held for 5 cycles while input is offered.
    out_ready = 1'b0;
    frame_buf[0] = 8'h11; frame_buf[1] = 8'h33; frame_buf[2] = 8'h22;
    send_frame(3, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_in_ready", 32'(u_in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(u_out_valid), 32'd1);
      check_eq("bp_value_stable", 32'(u_out_value), 32'h33);
      check_eq("bp_index_stable", 32'(u_out_index), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check_eq("bp_in_ready_restored", 32'(u_in_ready), 32'd1);
    frame_buf[0] = 8'h40; frame_buf[1] = 8'h10; frame_buf[2] = 8'h40;
    send_frame(3, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Mode toggled after the first sample has no effect: min of 3,1,7.
    frame_buf[0] = 8'h03; frame_buf[1] = 8'h01; frame_buf[2] = 8'h07;
    send_frame(3, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Single-sample frame.
    frame_buf[0] = 8'hC5;
    send_frame(1, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Random frames covering lengths 1..16 and both modes.
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(1, FRAME_LEN));
      ul = (n < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < FRAME_LEN; i++) frame_buf[i] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 2));
      send_frame(n, 1'($urandom_range(0, 1)), ul, 1'b0);
    end
    wait_drain();

    // Reset mid-frame after 5 of 16 samples: partial frame discarded.
    for (int i = 0; i < FRAME_LEN; i++) frame_buf[i] = 8'(i + 8'h30);
    min_max = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = frame_buf[i]; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame_buf[0] = 8'h09; frame_buf[1] = 8'h04;
    send_frame(2, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check_eq("queues_empty", 32'(exp_u.size() + exp_s.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
